mem_sequencer: RTL and testbench

- Initiator-side controller for the CPU data memory block (address register + synchronous 256x8 RAM).
- Accepts one request at a time over a valid/ready handshake: read or write, direct or indirect (pointer-through-memory) addressing.
- Generates the memory block's control strobes (wAR, srcA, wM) in the required cycle order, and returns read data with a one-cycle completion pulse.
- Sits between the control unit and the memory block, replacing hand-sequenced strobes in the control FSM.

---
 rtl/mem_sequencer.sv | 129 ++++++++++++
 tb/tb_mem_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_sequencer
// Description : Initiator-side sequencer for the CPU data memory block
//               (address register AR + synchronous 256x8 RAM). Accepts one
//               read/write request at a time, direct or indirect (pointer
//               held in memory), drives the wAR/srcA/wM strobes in the order
//               the memory block needs, and returns read data with a
//               one-cycle completion pulse.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               req_valid/req_ready  - request handshake (ready only in IDLE)
//               req_write            - 1 = write, 0 = read
//               req_indirect         - 1 = target address is mem[req_addr]
//               req_addr, req_wdata  - request address / write data
//               rsp_valid, rsp_data  - completion pulse / read result
//               busy                 - sequencer is not idle
//               mem_addr, mem_r      - latched address / data to the memory
//               mem_srcA, mem_wAR    - AR source select / AR write enable
//               mem_wM               - RAM write enable
//               mem_m                - registered RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_indirect,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_r,
  output logic                  mem_srcA,
  output logic                  mem_wAR,
  output logic                  mem_wM,
  input  logic [DATA_WIDTH-1:0] mem_m
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_AR  = 3'd1,
    S_PTR_RD  = 3'd2,
    S_PTR_SET = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_DONE = 3'd5,
    S_WRITE   = 3'd6
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_write;
  logic                  r_indirect;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic                  w_idle;

  assign w_idle = (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_indirect  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      // Completion is a single-cycle pulse; only the finishing states raise it.
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_write    <= req_write;
            r_indirect <= req_indirect;
            r_state    <= S_SET_AR;
          end
        end
        S_SET_AR: begin
          if (r_indirect)   r_state <= S_PTR_RD;
          else if (r_write) r_state <= S_WRITE;
          else              r_state <= S_RD_WAIT;
        end
        // RAM output is registered: one idle cycle before the pointer is on M.
        S_PTR_RD: r_state <= S_PTR_SET;
        S_PTR_SET: begin
          if (r_write) r_state <= S_WRITE;
          else         r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: r_state <= S_RD_DONE;
        S_RD_DONE: begin
          r_rsp_data  <= mem_m;
          r_rsp_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_WRITE: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_idle;
  assign busy      = !w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_addr  = r_addr;
  assign mem_r     = r_wdata;

  // Moore strobe decode, forced low while reset is asserted so an aborted
  // access cannot disturb AR or the RAM in the reset cycle.
  assign mem_wAR  = !rst && ((r_state == S_SET_AR) || (r_state == S_PTR_SET));
  assign mem_srcA = !rst && (r_state == S_PTR_SET);
  assign mem_wM   = !rst && (r_state == S_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sequencer
// Description : Self-checking bench for mem_sequencer with a behavioural
//               model of the AR + registered RAM memory block, a directed
//               vector table, hand-written busy/reset sequences and random
//               transactions checked against a shadow-memory reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic       req_indirect = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_r;
  logic       mem_srcA;
  logic       mem_wAR;
  logic       mem_wM;
  logic [7:0] mem_m;

  always #5 clk = ~clk;

  mem_sequencer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_indirect(req_indirect),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .mem_addr(mem_addr), .mem_r(mem_r), .mem_srcA(mem_srcA),
    .mem_wAR(mem_wAR), .mem_wM(mem_wM), .mem_m(mem_m)
  );

  // Memory block model: AR register, RAM with registered output M.
  logic [7:0] ram [256];
  logic [7:0] ar = 8'h00;
  logic [7:0] m  = 8'h00;
  logic       pk_en = 1'b0;
  logic [7:0] pk_addr = 8'h00;
  logic [7:0] pk_data = 8'h00;

  always @(posedge clk) begin
    if (pk_en)  ram[pk_addr] <= pk_data;
    if (mem_wM) ram[ar] <= mem_r;
    m <= ram[ar];
    if (mem_wAR) ar <= mem_srcA ? m : mem_addr;
  end
  assign mem_m = m;

  // Event counters.
  int n_xfer = 0;
  int n_wm   = 0;
  int n_rsp  = 0;
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) n_xfer <= n_xfer + 1;
    if (mem_wM)    n_wm  <= n_wm + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: shadow memory updated by transaction semantics.
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd = 8'h00;

  task automatic ref_txn(input bit wr, input bit ind, input logic [7:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] data,
                         output logic [31:0] src, output logic [31:0] war, output logic [31:0] wm);
    logic [7:0] t;
    t   = ind ? ref_mem[a] : a;
    lat = 3 + (wr ? 0 : 1) + (ind ? 2 : 0);
    src = ind ? 32'h8 : 32'h0;
    war = ind ? 32'hA : 32'h2;
    wm  = wr ? (32'h1 << (lat - 1)) : 32'h0;
    if (wr) begin
      ref_mem[t] = d;
      data = last_rd;
    end else begin
      data = ref_mem[t];
      last_rd = data;
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  // Issue one request from an IDLE cycle and follow it to completion.
  // Cycle n is the n-th cycle after the transfer edge.
  task automatic do_req(input bit wr, input bit ind, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rdata,
                        output logic [31:0] src, output logic [31:0] war, output logic [31:0] wm);
    req_write = wr; req_indirect = ind; req_addr = a; req_wdata = d; req_valid = 1'b1;
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = ~a; req_wdata = ~d; req_write = ~wr; req_indirect = ~ind;
    check("latched_addr", {24'd0, mem_addr}, {24'd0, a});
    check("latched_wdata", {24'd0, mem_r}, {24'd0, d});
    check("busy_ready", {30'd0, busy, req_ready}, 32'd2);
    lat = 0; src = '0; war = '0; wm = '0;
    for (int n = 1; n <= 20; n++) begin
      if (mem_srcA) src[n] = 1'b1;
      if (mem_wAR)  war[n] = 1'b1;
      if (mem_wM)   wm[n]  = 1'b1;
      if (rsp_valid) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    rdata = rsp_data;
    if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    bit          wr;
    bit          ind;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  data;
    logic [31:0] src;
    logic [31:0] war;
    logic [31:0] wm;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          lat, elat;
    logic [7:0]  rd, erd;
    logic [31:0] src, war, wm, esrc, ewar, ewm;
    int          bad, x0, w0, r0;
    bit          wr, ind;
    logic [7:0]  a, d;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 4, 8'hA5, 32'h0, 32'h2, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 8'h20, 8'h00, 6, 8'h5C, 32'h8, 32'hA, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 8'h07, 8'h3C, 3, 8'h5C, 32'h0, 32'h2, 32'h4};
    vecs[3] = '{1'b0, 1'b0, 8'h07, 8'h00, 4, 8'h3C, 32'h0, 32'h2, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 8'h40, 8'h99, 5, 8'h3C, 32'h8, 32'hA, 32'h10};
    vecs[5] = '{1'b0, 1'b1, 8'h40, 8'h00, 6, 8'h99, 32'h8, 32'hA, 32'h0};

    // Preload under reset.
    #1;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'h10, 8'hA5); poke(8'h20, 8'h30); poke(8'h30, 8'h5C); poke(8'h40, 8'hFF);
    poke(8'h50, 8'h60); poke(8'h60, 8'h11);
    check("strobes_in_rst", {29'd0, mem_wAR, mem_srcA, mem_wM}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    check("rst_ready_busy", {30'd0, req_ready, busy}, 32'd2);
    check("rst_rsp", {23'd0, rsp_valid, rsp_data}, 32'd0);
    check("rst_latched", {16'd0, mem_addr, mem_r}, 32'd0);
    check("rst_strobes", {29'd0, mem_wAR, mem_srcA, mem_wM}, 32'd0);

    // Directed table, issued back to back (each new request in the rsp cycle).
    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].ind, vecs[i].addr, vecs[i].wdata, lat, rd, src, war, wm);
      ref_txn(vecs[i].wr, vecs[i].ind, vecs[i].addr, vecs[i].wdata, elat, erd, esrc, ewar, ewm);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_data", i), {24'd0, rd}, {24'd0, vecs[i].data});
      check($sformatf("vec%0d_srcA", i), src, vecs[i].src);
      check($sformatf("vec%0d_wAR", i), war, vecs[i].war);
      check($sformatf("vec%0d_wM", i), wm, vecs[i].wm);
    end
    check("ram_ff", {24'd0, ram[8'hFF]}, 32'h99);
    check("ram_40", {24'd0, ram[8'h40]}, 32'hFF);
    check("ram_07", {24'd0, ram[8'h07]}, 32'h3C);

    // Request held while busy: second request must wait and be taken once.
    @(posedge clk); #1;
    x0 = n_xfer;
    req_write = 1'b0; req_indirect = 1'b0; req_addr = 8'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 8'h30;
    bad = 0; lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (rsp_valid) begin lat = n; break; end
      if (req_ready) bad++;
      @(posedge clk); #1;
    end
    check("hold_ready_low", bad, 0);
    check("hold_first_lat", lat, 4);
    check("hold_first_data", {24'd0, rsp_data}, 32'hA5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (rsp_valid) begin lat = n; break; end
      @(posedge clk); #1;
    end
    check("hold_second_lat", lat, 4);
    check("hold_second_data", {24'd0, rsp_data}, 32'h5C);
    check("hold_xfers", n_xfer - x0, 2);
    last_rd = 8'h5C;

    // Reset in cycle 3 of an indirect write via 0x50 -> target 0x60.
    @(posedge clk); #1;
    req_write = 1'b1; req_indirect = 1'b1; req_addr = 8'h50; req_wdata = 8'h77; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    w0 = n_wm; r0 = n_rsp;
    rst = 1'b1;
    #1;
    check("abort_strobes", {29'd0, mem_wAR, mem_srcA, mem_wM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("abort_no_wm", n_wm - w0, 0);
    check("abort_no_rsp", n_rsp - r0, 0);
    check("abort_idle", {30'd0, busy, req_ready}, 32'd1);
    check("abort_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("abort_target", {24'd0, ram[8'h60]}, 32'h11);
    last_rd = 8'h00;

    // Random transactions against the shadow-memory reference.
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      ind = 1'($urandom);
      a   = 8'($urandom);
      d   = 8'($urandom);
      if (($urandom % 3) == 0) begin @(posedge clk); #1; end
      ref_txn(wr, ind, a, d, elat, erd, esrc, ewar, ewm);
      do_req(wr, ind, a, d, lat, rd, src, war, wm);
      check($sformatf("rnd%0d_lat", i), lat, elat);
      check($sformatf("rnd%0d_data", i), {24'd0, rd}, {24'd0, erd});
      check($sformatf("rnd%0d_strobes", i), src | war | wm, esrc | ewar | ewm);
    end
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("final_mem", bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
